cycle_counter_unit: RTL

CYCLE_COUNTER_UNIT -- requirements
Module: cycle_counter_unit

---
 rtl/cpu_pkg.sv | 13 +
 rtl/cycle_snap_hs.sv | 38 +++
 rtl/cycle_counter_unit.sv | 111 +++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared constants and the counter FSM state encoding
package cpu_pkg;

    // Default width of the cycle count, snapshot value and compare target.
    localparam int CYC_BUS_WIDTH = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HOLD = 2'd2
    } cyc_state_t;

endpackage

// File: rtl/cycle_snap_hs.sv
// rtl/cycle_snap_hs.sv - four-phase snapshot responder capturing the live count
//
// Ports:
//   CLK       system clock, rising edge active
//   RESET_N   asynchronous active-low reset
//   count     live count to capture
//   snap_req  four-phase request
//   snap_ack  four-phase acknowledge (registered)
//   snap_val  captured count, stable while snap_ack is high
module cycle_snap_hs #(
    parameter int BUS_WIDTH = 32
) (
    input  logic                 CLK,
    input  logic                 RESET_N,
    input  logic [BUS_WIDTH-1:0] count,
    input  logic                 snap_req,
    output logic                 snap_ack,
    output logic [BUS_WIDTH-1:0] snap_val
);

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            snap_ack <= 1'b0;
            snap_val <= '0;
        end else begin
            // A new capture is only taken once the previous handshake has
            // fully returned to zero (ack low), so snap_val never changes
            // while the requester may be reading it.
            if (snap_req && !snap_ack) begin
                snap_val <= count;
                snap_ack <= 1'b1;
            end else if (!snap_req && snap_ack) begin
                snap_ack <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/cycle_counter_unit.sv
// rtl/cycle_counter_unit.sv - IDLE/RUN/HOLD cycle counter with wrap flag, snapshot and optional compare
//
// Optional feature: define CYCLE_CMP_EN to build the compare-match logic.
//
// Ports:
//   CLK        system clock, rising edge active
//   RESET_N    asynchronous active-low reset
//   start      pulse: enter or resume counting
//   halt       pulse: freeze the count
//   clear      pulse: zero the count and wrap flag, return to IDLE
//   snap_req   four-phase snapshot request
//   snap_ack   four-phase snapshot acknowledge
//   snap_val   captured count
//   CLK_cycle  live registered cycle count
//   running    high while the state is RUN
//   wrap       sticky overflow flag
//   cmp_val    compare target (ignored without CYCLE_CMP_EN)
//   cmp_hit    one-cycle compare-match pulse (0 without CYCLE_CMP_EN)
module cycle_counter_unit
    import cpu_pkg::*;
#(
    parameter int BUS_WIDTH = CYC_BUS_WIDTH
) (
    input  logic                 CLK,
    input  logic                 RESET_N,
    input  logic                 start,
    input  logic                 halt,
    input  logic                 clear,
    input  logic                 snap_req,
    output logic                 snap_ack,
    output logic [BUS_WIDTH-1:0] snap_val,
    output logic [BUS_WIDTH-1:0] CLK_cycle,
    output logic                 running,
    output logic                 wrap,
    input  logic [BUS_WIDTH-1:0] cmp_val,
    output logic                 cmp_hit
);

    localparam logic [BUS_WIDTH-1:0] ONE = {{(BUS_WIDTH-1){1'b0}}, 1'b1};

    cyc_state_t state;
    logic       do_inc;

    // Counting happens on edges where the registered state is RUN and no
    // higher-priority control is sampled; start in RUN does not block it.
    assign do_inc = (state == ST_RUN) && !clear && !halt;

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state     <= ST_IDLE;
            CLK_cycle <= '0;
            wrap      <= 1'b0;
            running   <= 1'b0;
        end else if (clear) begin
            state     <= ST_IDLE;
            CLK_cycle <= '0;
            wrap      <= 1'b0;
            running   <= 1'b0;
        end else if (halt) begin
            // halt outranks start; outside RUN it is a no-op.
            if (state == ST_RUN) begin
                state   <= ST_HOLD;
                running <= 1'b0;
            end
        end else begin
            if (start && state != ST_RUN) begin
                state   <= ST_RUN;
                running <= 1'b1;
            end
            if (do_inc) begin
                CLK_cycle <= CLK_cycle + ONE;
                if (&CLK_cycle) begin
                    wrap <= 1'b1;
                end
            end
        end
    end

`ifdef CYCLE_CMP_EN
    // inc_d marks that the previous edge was an increment, so equality
    // produced by clear or reset never raises cmp_hit.
    logic inc_d;

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            inc_d   <= 1'b0;
            cmp_hit <= 1'b0;
        end else begin
            inc_d   <= do_inc;
            cmp_hit <= inc_d && (CLK_cycle == cmp_val);
        end
    end
`else
    logic unused_cmp_val;

    assign unused_cmp_val = ^cmp_val;
    assign cmp_hit        = 1'b0;
`endif

    cycle_snap_hs #(
        .BUS_WIDTH (BUS_WIDTH)
    ) u_snap (
        .CLK      (CLK),
        .RESET_N  (RESET_N),
        .count    (CLK_cycle),
        .snap_req (snap_req),
        .snap_ack (snap_ack),
        .snap_val (snap_val)
    );

endmodule
